// File: rtl/cpu_sequencer.sv
// Eight-phase control sequencer for the basic 8-bit CPU: walks fetch/execute
// phases, decodes the IR opcode into datapath strobes, and owns halt/memory-wait stalls.
module cpu_sequencer #(
  parameter int PHASE_W = 3,
  parameter int OP_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt,
  output logic [PHASE_W-1:0] phase
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [OP_W-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  phase_e  phase_q, phase_d;
  logic    halted_q, halted_d;
  opcode_e op;
  logic    is_alu, is_sto, is_jmp, is_skz, is_hlt;

  // Only meaningful from phase 4 on; the IR is reloaded on the edge ending phase 2.
  assign op     = opcode_e'(opcode);
  assign is_alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign is_sto = (op == OP_STO);
  assign is_jmp = (op == OP_JMP);
  assign is_skz = (op == OP_SKZ);
  assign is_hlt = (op == OP_HLT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    phase_d  = phase_e'(phase_q + 1'b1);
    halted_d = halted_q;
    sel      = 1'b0;
    rd       = 1'b0;
    ld_ir    = 1'b0;
    inc_pc   = 1'b0;
    ld_pc    = 1'b0;
    ld_ac    = 1'b0;
    wr       = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;

    if (halted_q) begin
      halt    = 1'b1;
      phase_d = phase_q;
    end else begin
      case (phase_q)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
          if (!mem_ready) phase_d = phase_q;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          // Halt freezes the phase here so a halted CPU reads back phase 4.
          if (is_hlt) begin
            halt     = 1'b1;
            halted_d = 1'b1;
            phase_d  = phase_q;
          end
        end
        OP_FETCH: begin
          rd = is_alu;
          if (is_alu && !mem_ready) phase_d = phase_q;
        end
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: phase_d = INST_ADDR;
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: per-phase strobe tables for each
// opcode class, memory-wait stalls, halt, and reset abort.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
  logic [8:0] strobes;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, LDA = 3'd5,
                         STO = 3'd6, JMP = 3'd7;

  // Strobe order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_P0   = 9'b100000000;
  localparam logic [8:0] S_P1   = 9'b110000000;
  localparam logic [8:0] S_P23  = 9'b111000000;
  localparam logic [8:0] S_INC  = 9'b000100000;
  localparam logic [8:0] S_RD   = 9'b010000000;
  localparam logic [8:0] S_LDAC = 9'b010001000;
  localparam logic [8:0] S_DE   = 9'b000000010;
  localparam logic [8:0] S_WR   = 9'b000000110;
  localparam logic [8:0] S_LDPC = 9'b000010000;
  localparam logic [8:0] S_HLT  = 9'b000100001;
  localparam logic [8:0] S_HALT = 9'b000000001;
  localparam logic [35:0] FETCH = {S_P0, S_P1, S_P23, S_P23};

  cpu_sequencer #(.PHASE_W(3), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Check one cycle at the falling edge, then move to just after the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] exp_ph, input logic [8:0] exp_st);
    @(negedge clk);
    check({tag, "_phase"}, {6'd0, phase}, {6'd0, exp_ph});
    check({tag, "_strobes"}, strobes, exp_st);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic z,
                        input logic [71:0] exp);
    opcode    = op;
    zero      = z;
    mem_ready = 1'b1;
    for (int p = 0; p < 8; p++)
      cyc($sformatf("%s_p%0d", tag, p), 3'(p), exp[71-9*p -: 9]);
  endtask

  initial begin
    rst = 1'b1; opcode = ADD; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state (phase 0) is also the first cycle of the ADD table.
    run_op("add",    ADD, 1'b0, {FETCH, S_INC, S_RD,   S_RD,   S_LDAC});
    run_op("sto",    STO, 1'b0, {FETCH, S_INC, S_NONE, S_DE,   S_WR});
    run_op("skz_z1", SKZ, 1'b1, {FETCH, S_INC, S_NONE, S_INC,  S_NONE});
    run_op("skz_z0", SKZ, 1'b0, {FETCH, S_INC, S_NONE, S_NONE, S_NONE});
    run_op("jmp",    JMP, 1'b0, {FETCH, S_INC, S_NONE, S_LDPC, S_LDPC});

    // Instruction-fetch wait: phase 1 held for 4 cycles, then LDA operand wait at phase 5.
    opcode = LDA; zero = 1'b0; mem_ready = 1'b1;
    cyc("st1_p0", 3'd0, S_P0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("st1_hold%0d", i), 3'd1, S_P1);
    mem_ready = 1'b1;
    cyc("st1_rel", 3'd1, S_P1);
    cyc("st1_p2", 3'd2, S_P23);
    cyc("st1_p3", 3'd3, S_P23);
    cyc("st1_p4", 3'd4, S_INC);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) cyc($sformatf("st5_hold%0d", i), 3'd5, S_RD);
    mem_ready = 1'b1;
    cyc("st5_rel", 3'd5, S_RD);
    cyc("st5_p6", 3'd6, S_RD);
    cyc("st5_p7", 3'd7, S_LDAC);

    // JMP ignores mem_ready at phase 5.
    opcode = JMP;
    for (int p = 0; p < 5; p++) cyc($sformatf("jnw_p%0d", p), 3'(p), FETCH[35-9*(p%4) -: 9] & {9{p < 4}} | S_INC & {9{p == 4}});
    mem_ready = 1'b0;
    cyc("jnw_p5", 3'd5, S_NONE);
    cyc("jnw_p6", 3'd6, S_LDPC);
    cyc("jnw_p7", 3'd7, S_LDPC);
    mem_ready = 1'b1;

    // Halt: phase 4 shows halt+inc_pc even with mem_ready low, then frozen.
    opcode = HLT;
    cyc("hlt_p0", 3'd0, S_P0);
    cyc("hlt_p1", 3'd1, S_P1);
    cyc("hlt_p2", 3'd2, S_P23);
    cyc("hlt_p3", 3'd3, S_P23);
    mem_ready = 1'b0;
    cyc("hlt_p4", 3'd4, S_HLT);
    opcode = ADD; zero = 1'b1;
    for (int i = 0; i < 22; i++) begin
      mem_ready = i[0];
      cyc($sformatf("halted%0d", i), 3'd4, S_HALT);
    end
    mem_ready = 1'b1;
    rst = 1'b1;
    cyc("hlt_rst", 3'd4, S_HALT);
    rst = 1'b0;
    cyc("after_rst", 3'd0, S_P0);

    // Store aborted by reset during phase 6: no write ever appears.
    opcode = STO; zero = 1'b0;
    cyc("ab_p1", 3'd1, S_P1);
    cyc("ab_p2", 3'd2, S_P23);
    cyc("ab_p3", 3'd3, S_P23);
    cyc("ab_p4", 3'd4, S_INC);
    cyc("ab_p5", 3'd5, S_NONE);
    rst = 1'b1;
    cyc("ab_p6", 3'd6, S_DE);
    rst = 1'b0;
    cyc("ab_after", 3'd0, S_P0);
    cyc("ab_p1b", 3'd1, S_P1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase control sequencer for the basic 8-bit CPU.
- Sits directly downstream of the instruction register. It consumes the 3-bit opcode the IR holds and the accumulator zero flag.
- Each cycle it drives the datapath strobes: IR load, PC increment/load, memory read/write, accumulator load, address-mux select and data-bus enable.
- It also owns halt and memory-wait stalling.

Parameters:
- PHASE_W, 3, width of the phase counter (fixed at 3; eight phases).
- OP_W, 3, opcode width; must match the IR opcode output.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  OP_W  current opcode from the instruction register
- zero  input  1  accumulator-is-zero flag
- mem_ready  input  1  memory read data valid this cycle
- sel  output  1  address mux: 1 = PC, 0 = IR operand address
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  program counter increment
- ld_pc  output  1  program counter load (jump)
- ld_ac  output  1  accumulator load
- wr  output  1  memory write enable
- data_e  output  1  drive accumulator onto data bus
- halt  output  1  CPU halted
- phase  output  PHASE_W  current phase (debug/trace)

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- State: 3-bit phase register plus a 1-bit halted register.
- Outputs are combinational decodes of phase, halted, opcode and zero. They are never registered.
- Phases and outputs (any output not listed is 0):
  - 0 INST_ADDR: sel.
  - 1 INST_FETCH: sel, rd.
  - 2 INST_LOAD: sel, rd, ld_ir.
  - 3 IDLE: sel, rd, ld_ir.
  - 4 OP_ADDR: inc_pc; halt = (opcode==HLT).
  - 5 OP_FETCH: rd = ALUOP.
  - 6 ALU_OP: rd = ALUOP; inc_pc = (SKZ & zero); ld_pc = JMP; data_e = STO.
  - 7 STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO.
- Advance: phase increments by 1 each cycle and wraps 7 -> 0. There is no skipped phase.
- Opcode timing: opcode is only decoded in phases 4-7. It is ignored in phases 0-3, because the IR updates on the edge ending phase 2.
- Stall: phase holds, with outputs unchanged, while mem_ready==0 in either of these cases:
  - phase 1;
  - phase 5 with ALUOP.
- mem_ready is ignored in all other phases and opcodes.
- Stalls have no timeout.
- Halt:
  - In phase 4 with opcode==HLT: inc_pc=1 and halt=1 for that cycle, then halted is set on the next edge.
  - While halted=1: halt=1, all other strobes 0, phase frozen at 4.
  - Only rst clears halted.
- Reset:
  - When rst=1 at a rising edge: phase=0 and halted=0 next cycle. Reset overrides stall, halt and advance.
  - Output values after reset: sel=1, phase=0, all other outputs 0.
  - Reset asserted mid-instruction aborts it. No wr or ld_pc is issued from the aborted instruction after that edge.
- Simultaneous events: HLT in phase 4 ignores mem_ready. SKZ with zero=0 gives inc_pc=0 in phase 6.
- Invariants:
  - wr is never 1 outside phase 7.
  - ld_ir is never 1 outside phases 2-3.
  - At most one of ld_pc/inc_pc is 1 in any cycle.

Test Plan:
- Reset then free-run with mem_ready=1 and opcode=ADD -> phase sequence 0..7,0. ld_ir=1 in phases 2-3 only; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 in phase 7 only; inc_pc=1 in phase 4 only.
- opcode=STO, mem_ready=1 -> data_e=1 in phases 6-7; wr=1 in phase 7 only; rd=0 in phases 5-7; ld_ac=0 throughout.
- opcode=SKZ with zero=1 -> inc_pc=1 in phases 4 and 6. Repeat with zero=0 -> inc_pc=1 in phase 4 only. opcode=JMP -> ld_pc=1 in phases 6-7.
- mem_ready=0 for 3 cycles at phase 1 -> phase stays 1 for 4 cycles with sel=rd=1. opcode=LDA, mem_ready=0 for 2 cycles at phase 5 -> phase 5 held 3 cycles. opcode=JMP, mem_ready=0 at phase 5 -> no stall.
- opcode=HLT -> phase 4 cycle shows halt=1 and inc_pc=1. Thereafter halt=1, phase=4, all strobes 0 for 20+ cycles. rst=1 for one cycle -> phase=0, halt=0, sel=1.
- opcode=STO, rst=1 asserted during phase 6 -> next cycle phase=0. wr stays 0; the aborted store never writes.
